// File: rtl/calc_display.sv
// Serial digit bus receiver with atomic frame commit and 8-digit multiplexed 7-segment drive.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits of the committed frame.
module calc_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int NDIG        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic       frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [3:0]    shadow [NDIG];
  logic [3:0]    frame  [NDIG];
  logic          err_lat;
  logic [2:0]    scan_idx;
  logic [CW-1:0] div_cnt;
  logic          capture;
  logic          commit;
  logic          wrap;
  logic [7:0]    glyph;

  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 8'hC0;
      4'd1:    decode = 8'hF9;
      4'd2:    decode = 8'hA4;
      4'd3:    decode = 8'hB0;
      4'd4:    decode = 8'h99;
      4'd5:    decode = 8'h92;
      4'd6:    decode = 8'h82;
      4'd7:    decode = 8'hF8;
      4'd8:    decode = 8'h80;
      4'd9:    decode = 8'h90;
      default: decode = 8'hBF;
    endcase
  endfunction

  // Once an error is latched the bus is ignored until reset; pos 8..15 is never captured.
  assign capture = !err_lat && (status == 2'b01) && !pos[3];
  assign commit  = capture && (pos[2:0] == 3'd7);
  assign wrap    = (div_cnt == CW'(REFRESH_DIV - 1));

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0] blank_mask;
  logic            zero_run;

  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_run      = zero_run & (frame[i] == 4'd0);
      blank_mask[i] = zero_run & (i != 0);
    end
  end
`endif

  always_comb begin
    glyph = 8'hFF;
    if (err_lat) begin
      case (scan_idx)
        3'd3:    glyph = 8'h86;
        3'd2:    glyph = 8'hAF;
        3'd1:    glyph = 8'hAF;
        3'd0:    glyph = 8'hA3;
        default: glyph = 8'hFF;
      endcase
    end else begin
      glyph = decode(frame[scan_idx]);
`ifdef LEADING_ZERO_BLANK_EN
      if (blank_mask[scan_idx]) glyph = 8'hFF;
`endif
    end
  end

  // Slot 7 of a committing frame comes straight from the bus, not the stale shadow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NDIG; i++) begin
        shadow[i] <= '0;
        frame[i]  <= '0;
      end
      err_lat    <= 1'b0;
      scan_idx   <= '0;
      div_cnt    <= '0;
      an         <= 8'hFF;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      if (status == 2'b00) err_lat <= 1'b1;
      if (capture) shadow[pos[2:0]] <= data;
      if (commit) begin
        for (int i = 0; i < NDIG - 1; i++) frame[i] <= shadow[i];
        frame[NDIG-1] <= data;
      end
      frame_done <= commit;
      if (wrap) begin
        div_cnt  <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
      an  <= ~(8'b1 << scan_idx);
      seg <= glyph;
    end
  end

endmodule

// File: tb/tb_calc_display.sv
// Scoreboard bench for calc_display: frame_done pulses are queued at stimulus time, display slots checked against a model.
module tb_calc_display;

  localparam int RDIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] status = 2'b10;
  logic [3:0] data = '0;
  logic [3:0] pos = '0;
  logic [7:0] an;
  logic [7:0] seg;
  logic       frame_done;

  int total = 0;
  int bad = 0;

  logic [3:0] mShadow [8];
  logic [3:0] mFrame  [8];
  logic       mErr;
  bit         fdQ [$];

  calc_display #(.REFRESH_DIV(RDIV), .NDIG(8)) dut (
    .clock(clock), .reset(reset), .status(status), .data(data), .pos(pos),
    .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] decodeRef(input logic [3:0] d);
    logic [7:0] t [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return (d > 4'd9) ? 8'hBF : t[d];
  endfunction

  function automatic logic [7:0] expGlyph(input int i);
    bit allZero;
    if (mErr) begin
      case (i)
        3: return 8'h86;
        2: return 8'hAF;
        1: return 8'hAF;
        0: return 8'hA3;
        default: return 8'hFF;
      endcase
    end
    allZero = 1'b1;
    for (int k = i; k < 8; k++) if (mFrame[k] != 4'd0) allZero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (allZero && i >= 1) return 8'hFF;
`endif
    return decodeRef(mFrame[i]);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Each frame_done seen must match a commit queued by the stimulus.
  always @(negedge clock) begin
    if (reset && frame_done) begin
      checkOutput("fd_pending", 32'(fdQ.size() > 0), 1);
      if (fdQ.size() > 0) void'(fdQ.pop_front());
    end
  end

  task automatic applyStimulus(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
    status = st;
    pos    = p;
    data   = d;
    if (st == 2'b00) mErr = 1'b1;
    else if (st == 2'b01 && !mErr && p < 4'd8) begin
      mShadow[p[2:0]] = d;
      if (p == 4'd7) begin
        for (int k = 0; k < 8; k++) mFrame[k] = mShadow[k];
        fdQ.push_back(1'b1);
      end
    end
    tick();
    status = 2'b10;
  endtask

  task automatic sendFrame(input logic [31:0] value);
    for (int p = 0; p < 8; p++) applyStimulus(2'b01, 4'(p), value[4*p +: 4]);
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    checkOutput("rst_an", 32'(an), 32'hFF);
    checkOutput("rst_seg", 32'(seg), 32'hFF);
    checkOutput("rst_fd", 32'(frame_done), 0);
    for (int k = 0; k < 8; k++) begin
      mShadow[k] = '0;
      mFrame[k]  = '0;
    end
    mErr = 1'b0;
    fdQ.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic checkDrained(input string tag);
    repeat (3) tick();
    checkOutput(tag, 32'(fdQ.size()), 0);
  endtask

  task automatic checkFrame(input string tag);
    logic [7:0] prevAn;
    logic [7:0] seen;
    int waited;
    int idx;
    repeat (2) tick();
    seen = '0;
    for (int s = 0; s < 8; s++) begin
      prevAn = an;
      waited = 0;
      while (an == prevAn && waited < 3 * RDIV) begin
        tick();
        waited++;
      end
      checkOutput({tag, "_advance"}, 32'(an != prevAn), 1);
      idx = -1;
      for (int k = 0; k < 8; k++) if (an == ~(8'b1 << k)) idx = k;
      checkOutput({tag, "_an_onehot"}, 32'(idx >= 0), 1);
      if (idx >= 0) begin
        seen[idx] = 1'b1;
        checkOutput($sformatf("%s_d%0d", tag, idx), 32'(seg), 32'(expGlyph(idx)));
      end
    end
    checkOutput({tag, "_cover"}, 32'(seen), 32'hFF);
  endtask

  initial begin
    #2;
    doReset();
    checkFrame("after_reset");

    sendFrame(32'h12345678);
    checkDrained("fd_frame1");
    checkFrame("frame1");

    // Partial frame then ready: previous frame must stay on display.
    for (int p = 0; p < 6; p++) applyStimulus(2'b01, 4'(p), 4'd9);
    applyStimulus(2'b10, 4'd7, 4'd3);
    checkDrained("fd_partial");
    checkFrame("partial_held");

    sendFrame(32'h00000042);
    checkDrained("fd_42");
    checkFrame("value42");

    // Out-of-range pos while busy must not alias onto slot 1.
    applyStimulus(2'b01, 4'd0, 4'd1);
    applyStimulus(2'b01, 4'd1, 4'd2);
    applyStimulus(2'b01, 4'd2, 4'd3);
    applyStimulus(2'b01, 4'd9, 4'd5);
    applyStimulus(2'b01, 4'd3, 4'hB);
    applyStimulus(2'b01, 4'd4, 4'd6);
    applyStimulus(2'b01, 4'd5, 4'hF);
    applyStimulus(2'b01, 4'd6, 4'd0);
    applyStimulus(2'b01, 4'd7, 4'd7);
    checkDrained("fd_dash");
    checkFrame("dash_pos9");

    sendFrame(32'h87654321);
    sendFrame(32'h00000900);
    checkDrained("fd_b2b");
    checkFrame("back2back");

    // Reset with a half-written shadow: the stale digits must not reappear.
    for (int p = 0; p < 4; p++) applyStimulus(2'b01, 4'(p), 4'd9);
    repeat (3) tick();
    doReset();
    for (int p = 4; p < 8; p++) applyStimulus(2'b01, 4'(p), 4'(p - 3));
    checkDrained("fd_after_rst");
    checkFrame("rst_midframe");

    applyStimulus(2'b00, 4'd0, 4'd0);
    checkFrame("error");
    sendFrame(32'h11111111);
    checkDrained("fd_err_blocked");
    checkFrame("error_sticky");

    repeat (5) tick();
    doReset();
    checkFrame("err_cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
